// File: rtl/wb_delay_pipe.sv
// Write-back delay line: DEPTH register stages carrying result slots to the
// register-file write port, with stall/flush control and youngest-first forwarding.
module wb_delay_pipe #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_we,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] fwd_rt,
    output logic              out_valid,
    output logic              out_mem_to_reg,
    output logic              out_reg_we,
    output logic [DATA_W-1:0] out_wr_data,
    output logic [ADDR_W-1:0] out_rt,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [2:0]        fwd_stage,
    output logic [3:0]        occupancy
);
    typedef struct packed {
        logic              valid;
        logic              mem_to_reg;
        logic              reg_we;
        logic [DATA_W-1:0] wr_data;
        logic [ADDR_W-1:0] rt;
    } stage_t;

    stage_t             stg [DEPTH];
    stage_t             entry;
    logic [DEPTH-1:0]   vld_pipe;

    // A bubble never carries a write enable, whatever the upstream reg_we says.
    always_comb begin
        entry.valid      = in_valid;
        entry.mem_to_reg = in_mem_to_reg;
        entry.reg_we     = in_valid & in_reg_we;
        entry.wr_data    = in_mem_to_reg ? in_read_data : in_alu_result;
        entry.rt         = in_rt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
        end else if (flush) begin
            // Kill slots but leave payload in place; only valid/reg_we matter downstream.
            for (int i = 0; i < DEPTH; i++) begin
                stg[i].valid  <= 1'b0;
                stg[i].reg_we <= 1'b0;
            end
        end else if (!stall) begin
            stg[0] <= entry;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) vld_pipe[i] = stg[i].valid;
    end

    assign out_valid      = stg[DEPTH-1].valid;
    assign out_mem_to_reg = stg[DEPTH-1].mem_to_reg;
    assign out_reg_we     = stg[DEPTH-1].valid & stg[DEPTH-1].reg_we;
    assign out_wr_data    = stg[DEPTH-1].wr_data;
    assign out_rt         = stg[DEPTH-1].rt;

    // Scan oldest to youngest so the youngest matching writer is the last assignment.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        fwd_stage = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stg[i].valid && stg[i].reg_we && stg[i].rt == fwd_rt) begin
                fwd_hit   = 1'b1;
                fwd_data  = stg[i].wr_data;
                fwd_stage = 3'(i);
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + 4'(vld_pipe[i]);
    end
endmodule

// File: tb/tb_wb_delay_pipe.sv
// Bench for wb_delay_pipe: directed table, corner-case sequences and random
// traffic checked against a queue-based delay-line model.
module tb_wb_delay_pipe;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_mem_to_reg, in_reg_we, stall, flush;
    logic [DW-1:0] in_read_data, in_alu_result;
    logic [AW-1:0] in_rt, fwd_rt;
    logic          out_valid, out_mem_to_reg, out_reg_we, fwd_hit;
    logic [DW-1:0] out_wr_data, fwd_data;
    logic [AW-1:0] out_rt;
    logic [2:0]    fwd_stage;
    logic [3:0]    occupancy;

    wb_delay_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mem_to_reg(in_mem_to_reg),
        .in_reg_we(in_reg_we), .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_rt(in_rt), .stall(stall), .flush(flush), .fwd_rt(fwd_rt),
        .out_valid(out_valid), .out_mem_to_reg(out_mem_to_reg), .out_reg_we(out_reg_we),
        .out_wr_data(out_wr_data), .out_rt(out_rt), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fwd_stage(fwd_stage), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v, we, m2r;
        logic [DW-1:0] rd, alu;
        logic [AW-1:0] rt;
    } in_t;

    typedef struct {
        logic          v, we, m2r;
        logic [DW-1:0] data;
        logic [AW-1:0] rt;
    } slot_t;

    typedef struct {
        in_t           in;
        logic          e_v, e_we;
        logic [DW-1:0] e_data;
        logic [AW-1:0] e_rt;
        logic [3:0]    e_occ;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;
    slot_t mq[$];   // mq[0] youngest, mq[D-1] the write-back slot
    localparam logic [DW-1:0] A5 = {16{8'hA5}};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic in_t mk(input logic v, we, m2r, input logic [DW-1:0] rd, alu,
                               input logic [AW-1:0] rt);
        in_t x;
        x.v = v; x.we = we; x.m2r = m2r; x.rd = rd; x.alu = alu; x.rt = rt;
        return x;
    endfunction

    // Model of the delay line: a fixed-length queue that shifts only on plain cycles.
    task automatic model_step(input in_t x, input logic st, fl, rs);
        slot_t s;
        if (rs) begin
            for (int i = 0; i < D; i++) begin
                mq[i].v = 0; mq[i].we = 0; mq[i].m2r = 0; mq[i].data = '0; mq[i].rt = '0;
            end
        end else if (fl) begin
            for (int i = 0; i < D; i++) begin mq[i].v = 0; mq[i].we = 0; end
        end else if (!st) begin
            s.v = x.v; s.we = x.v && x.we; s.m2r = x.m2r;
            s.data = x.m2r ? x.rd : x.alu; s.rt = x.rt;
            mq.push_front(s);
            void'(mq.pop_back());
        end
    endtask

    task automatic model_check();
        int occ = 0;
        logic hit = 0;
        logic [DW-1:0] fd = '0;
        int fs = 0;
        for (int i = 0; i < D; i++) occ += int'(mq[i].v);
        for (int i = D - 1; i >= 0; i--)
            if (mq[i].v && mq[i].we && mq[i].rt == fwd_rt) begin hit = 1; fd = mq[i].data; fs = i; end
        chk("m_out_valid", DW'(out_valid), DW'(mq[D-1].v));
        chk("m_out_reg_we", DW'(out_reg_we), DW'(mq[D-1].v && mq[D-1].we));
        chk("m_out_m2r", DW'(out_mem_to_reg), DW'(mq[D-1].m2r));
        chk("m_out_wr_data", out_wr_data, mq[D-1].data);
        chk("m_out_rt", DW'(out_rt), DW'(mq[D-1].rt));
        chk("m_occupancy", DW'(occupancy), DW'(occ));
        chk("m_fwd_hit", DW'(fwd_hit), DW'(hit));
        chk("m_fwd_data", fwd_data, fd);
        chk("m_fwd_stage", DW'(fwd_stage), DW'(fs));
    endtask

    // One clock: drive, clock, advance model, compare 1 time unit after the edge.
    task automatic cyc(input in_t x, input logic st, fl, rs, input logic [AW-1:0] frt);
        in_valid = x.v; in_reg_we = x.we; in_mem_to_reg = x.m2r;
        in_read_data = x.rd; in_alu_result = x.alu; in_rt = x.rt;
        stall = st; flush = fl; reset = rs; fwd_rt = frt;
        @(posedge clk);
        model_step(x, st, fl, rs);
        #1;
        model_check();
    endtask

    in_t  idle;
    vec_t tbl[6];

    initial begin
        int first, seen_we, max_occ;
        int order[$];
        idle = mk(0, 0, 0, '0, '0, '0);
        for (int i = 0; i < D; i++) mq.push_back('{0, 0, 0, '0, '0});

        cyc(idle, 0, 0, 1, 0);
        cyc(mk(1, 1, 1, 1, 2, 3), 1, 1, 1, 0);
        chk("reset_occ", DW'(occupancy), 0);
        chk("reset_out_valid", DW'(out_valid), 0);
        chk("reset_out_data", out_wr_data, 0);

        // Directed table: ALU slot then load slot; latency D, bubbles after.
        tbl[0] = '{mk(1, 1, 0, '0, A5, 5),           0, 0, '0,       0, 1};
        tbl[1] = '{mk(1, 1, 1, 'h1234, 'hFFFF, 9),   0, 0, '0,       0, 2};
        tbl[2] = '{idle,                             0, 0, '0,       0, 2};
        tbl[3] = '{idle,                             1, 1, A5,       5, 2};
        tbl[4] = '{idle,                             1, 1, 'h1234,   9, 1};
        tbl[5] = '{idle,                             0, 0, 'h1234,   9, 0};
        for (int k = 0; k < 6; k++) begin
            cyc(tbl[k].in, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_valid", k), DW'(out_valid), DW'(tbl[k].e_v));
            chk($sformatf("tbl%0d_we", k), DW'(out_reg_we), DW'(tbl[k].e_we));
            if (tbl[k].e_v) chk($sformatf("tbl%0d_data", k), out_wr_data, tbl[k].e_data);
            if (tbl[k].e_v) chk($sformatf("tbl%0d_rt", k), DW'(out_rt), DW'(tbl[k].e_rt));
            chk($sformatf("tbl%0d_occ", k), DW'(occupancy), DW'(tbl[k].e_occ));
        end

        // Stall for two cycles while the third slot waits upstream.
        cyc(idle, 0, 0, 1, 0);
        first = -1; max_occ = 0;
        for (int k = 0; k < 12; k++) begin
            case (k)
                0:       cyc(mk(1, 1, 0, '0, 3, 3), 0, 0, 0, 0);
                1:       cyc(mk(1, 1, 0, '0, 4, 4), 0, 0, 0, 0);
                2, 3:    cyc(mk(1, 1, 0, '0, 5, 5), 1, 0, 0, 0);
                4:       cyc(mk(1, 1, 0, '0, 5, 5), 0, 0, 0, 0);
                default: cyc(idle, 0, 0, 0, 0);
            endcase
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (out_valid) begin
                order.push_back(int'(out_rt));
                if (first < 0) first = k;
            end
        end
        chk("stall_first_out", DW'(first), 5);
        chk("stall_count", DW'(order.size()), 3);
        if (order.size() == 3) begin
            chk("stall_order0", DW'(order[0]), 3);
            chk("stall_order1", DW'(order[1]), 4);
            chk("stall_order2", DW'(order[2]), 5);
        end
        chk("stall_max_occ", DW'(max_occ), 3);

        // Forwarding: youngest of two same-rt writers wins.
        cyc(idle, 0, 0, 1, 0);
        cyc(mk(1, 1, 0, '0, 'h11, 7), 0, 0, 0, 7);
        cyc(mk(1, 1, 0, '0, 'h22, 7), 0, 0, 0, 7);
        chk("fwd_hit7", DW'(fwd_hit), 1);
        chk("fwd_data7", fwd_data, 'h22);
        chk("fwd_stage7", DW'(fwd_stage), 0);
        fwd_rt = 8; #1;
        chk("fwd_hit8", DW'(fwd_hit), 0);
        chk("fwd_data8", fwd_data, 0);
        cyc(idle, 0, 0, 0, 7);
        chk("fwd_stage_aged", DW'(fwd_stage), 1);
        chk("fwd_data_aged", fwd_data, 'h22);

        // Flush with stall and a valid input in the same cycle.
        cyc(idle, 0, 0, 1, 0);
        seen_we = 0;
        cyc(mk(1, 1, 0, '0, 'h1, 1), 0, 0, 0, 0);
        cyc(mk(1, 1, 0, '0, 'h2, 2), 0, 0, 0, 0);
        cyc(mk(1, 1, 0, '0, 'h3, 3), 1, 1, 0, 0);
        chk("flush_occ", DW'(occupancy), 0);
        for (int k = 0; k < 6; k++) begin
            cyc(idle, 0, 0, 0, 0);
            if (out_reg_we) seen_we++;
        end
        chk("flush_no_we", DW'(seen_we), 0);

        // Reset while three slots are in flight, then a fresh slot.
        cyc(idle, 0, 0, 1, 0);
        cyc(mk(1, 1, 0, '0, 'hA, 10), 0, 0, 0, 0);
        cyc(mk(1, 1, 0, '0, 'hB, 11), 0, 0, 0, 0);
        cyc(mk(1, 1, 0, '0, 'hC, 12), 0, 0, 0, 0);
        chk("rst_pre_occ", DW'(occupancy), 3);
        cyc(mk(1, 1, 0, '0, 'hD, 13), 1, 1, 1, 10);
        chk("rst_occ", DW'(occupancy), 0);
        chk("rst_valid", DW'(out_valid), 0);
        chk("rst_we", DW'(out_reg_we), 0);
        chk("rst_rt", DW'(out_rt), 0);
        chk("rst_fwd", DW'(fwd_hit), 0);
        first = -1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) cyc(mk(1, 1, 0, '0, 'h20, 20), 0, 0, 0, 0);
            else cyc(idle, 0, 0, 0, 0);
            if (out_valid && first < 0) first = k;
        end
        chk("rst_release_lat", DW'(first), 3);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            in_t x;
            x = mk(1'($urandom), 1'($urandom), 1'($urandom),
                   {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, AW'($urandom_range(0, 7)));
            cyc(x, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0, AW'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_delay_pipe.md
WB_DELAY_PIPE -- requirements
Module: wb_delay_pipe

Interface
REQ-001 Parameter DATA_W, default 128, width of result and load data.
REQ-002 Parameter ADDR_W, default 7, width of destination register address.
REQ-003 Parameter DEPTH, default 4, legal 1..8, number of register stages from input to write-back.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 in_valid  input  1  slot at input carries an instruction.
REQ-007 in_mem_to_reg  input  1  1 selects in_read_data, 0 selects in_alu_result.
REQ-008 in_reg_we  input  1  instruction writes the register file.
REQ-009 in_read_data  input  DATA_W  load data.
REQ-010 in_alu_result  input  DATA_W  execute result.
REQ-011 in_rt  input  ADDR_W  destination register.
REQ-012 stall  input  1  hold all stages.
REQ-013 flush  input  1  kill all in-flight slots.
REQ-014 fwd_rt  input  ADDR_W  register address queried for forwarding.
REQ-015 out_valid, out_mem_to_reg, out_reg_we  output  1 each  final-stage flags.
REQ-016 out_wr_data  output  DATA_W  final-stage write data.
REQ-017 out_rt  output  ADDR_W  final-stage destination.
REQ-018 fwd_hit  output  1  matching in-flight writer exists.
REQ-019 fwd_data  output  DATA_W  data of youngest matching writer.
REQ-020 fwd_stage  output  3  stage index of youngest match (0 = youngest).
REQ-021 occupancy  output  4  count of stages with valid set, 0..DEPTH.

Function
REQ-022 Stage i (0..DEPTH-1) holds valid, mem_to_reg, reg_we, wr_data, rt; outputs are driven directly from stage DEPTH-1 flops.
REQ-023 Data select at entry: stage 0 wr_data <= in_mem_to_reg ? in_read_data : in_alu_result.
REQ-024 Normal cycle (no reset, flush, stall): stage 0 <= inputs, stage i <= stage i-1; latency exactly DEPTH cycles from input sample to out_*.
REQ-025 stall=1, flush=0: every stage holds all fields; inputs ignored (upstream holds them).
REQ-026 flush=1: every stage valid and reg_we cleared to 0 next edge, data and rt fields hold; flush overrides stall; in_valid on a flush cycle is dropped.
REQ-027 out_reg_we and out_valid only assert when stage DEPTH-1 valid=1; out_reg_we = valid & reg_we of that stage.
REQ-028 Slot with in_valid=0 enters as bubble: valid=0, reg_we=0 stored regardless of in_reg_we.
REQ-029 Forwarding combinational over all stages: match when valid=1, reg_we=1, rt==fwd_rt; lowest index wins.
REQ-030 No match: fwd_hit=0, fwd_data=0, fwd_stage=0.
REQ-031 Register 0 is a normal register; no address is special-cased in matching.
REQ-032 occupancy = popcount of stage valid bits, combinational from current flops.
REQ-033 DEPTH=1: stage 0 is the output stage; all rules above apply unchanged.

Reset
REQ-034 reset=1 at a posedge clears every field of every stage to 0; all outputs read 0 the following cycle.
REQ-035 Reset overrides flush and stall; in-flight slots are discarded, no write-back is issued for them.
REQ-036 No state exists outside the stage flops; first valid input after reset release emerges DEPTH cycles later.

Verification (DEPTH=4, DATA_W=128, ADDR_W=7)
REQ-037 in_valid=1, we=1, mem_to_reg=0, alu=0xA5..A5, rt=5 for one cycle -> out_valid=1, out_reg_we=1, out_wr_data=0xA5..A5, out_rt=5 exactly 4 cycles later, for one cycle.
REQ-038 mem_to_reg=1, read_data=0x1234, alu=0xFFFF, rt=9 -> out_wr_data=0x1234 at cycle +4.
REQ-039 Three back-to-back slots rt=3,4,5, stall=1 for 2 cycles after the second -> outputs delayed 2 cycles, order 3,4,5 preserved, occupancy never exceeds 3.
REQ-040 Slots rt=7 data 0x11 then rt=7 data 0x22 next cycle, fwd_rt=7 -> fwd_hit=1, fwd_data=0x22, fwd_stage=0; fwd_rt=8 -> fwd_hit=0, fwd_data=0.
REQ-041 Two valid slots in flight, flush=1 and stall=1 same cycle with in_valid=1 -> next cycle occupancy=0, no out_reg_we ever asserted for those slots.
REQ-042 Reset asserted while occupancy=3 -> next cycle all outputs 0, occupancy=0; next slot after release appears 4 cycles after entry.
